// File: rtl/odyssey_pkg.sv
// Shared writeback-stage definitions: load funct3 encodings, FSM states and
// default datapath sizes.
package odyssey_pkg;

  localparam int DEFAULT_DATA_WIDTH     = 32;
  localparam int DEFAULT_LOG2_REGISTERS = 5;

  localparam logic [2:0] F3_LB  = 3'd0;
  localparam logic [2:0] F3_LH  = 3'd1;
  localparam logic [2:0] F3_LW  = 3'd2;
  localparam logic [2:0] F3_LBU = 3'd4;
  localparam logic [2:0] F3_LHU = 3'd5;

  typedef enum logic [0:0] {
    WB_IDLE     = 1'b0,
    WB_WAIT_MEM = 1'b1
  } wb_state_t;

endpackage

// File: rtl/load_aligner.sv
// Combinational load-data alignment: selects byte/half/word from a little-endian
// word, sign- or zero-extends it, and flags misaligned halfword/word accesses.
module load_aligner
  import odyssey_pkg::*;
#(
  parameter int DW = DEFAULT_DATA_WIDTH
) (
  input  logic [2:0]    funct3,
  input  logic [1:0]    addr_lo,
  input  logic [DW-1:0] rdata,
  output logic [DW-1:0] data,
  output logic          misaligned
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Pick the addressed byte and halfword out of the response word.
  always_comb begin
    byte_s = 8'h00;
    case (addr_lo)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = rdata[7:0];
    endcase
    if (addr_lo[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
  end

  // Extend the selected lane; unknown funct3 encodings behave as LW.
  always_comb begin
    data       = rdata;
    misaligned = 1'b0;
    case (funct3)
      F3_LB: begin
        data       = {{(DW-8){byte_s[7]}}, byte_s};
        misaligned = 1'b0;
      end
      F3_LBU: begin
        data       = {{(DW-8){1'b0}}, byte_s};
        misaligned = 1'b0;
      end
      F3_LH: begin
        data       = {{(DW-16){half_s[15]}}, half_s};
        misaligned = addr_lo[0];
      end
      F3_LHU: begin
        data       = {{(DW-16){1'b0}}, half_s};
        misaligned = addr_lo[0];
      end
      default: begin
        data       = rdata;
        misaligned = (addr_lo != 2'b00);
      end
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage driving the register-file write port, with one load in
// flight and a retired-instruction counter. Optional bypass outputs: WB_FORWARD_EN.
module writeback_stage
  import odyssey_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int LOG2_REGISTERS = DEFAULT_LOG2_REGISTERS,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_valid,
  output logic                      ex_ready,
  input  logic [LOG2_REGISTERS-1:0] ex_rd,
  input  logic [DATA_WIDTH-1:0]     ex_result,
  input  logic                      ex_is_load,
  input  logic [2:0]                ex_funct3,
  input  logic [1:0]                ex_addr_lo,
  input  logic                      mem_rvalid,
  input  logic [DATA_WIDTH-1:0]     mem_rdata,
  output logic [LOG2_REGISTERS-1:0] addr_rd,
  output logic [DATA_WIDTH-1:0]     data_rd,
  output logic                      rf_enable,
  output logic                      load_misalign,
`ifdef WB_FORWARD_EN
  output logic                      fwd_valid,
  output logic [LOG2_REGISTERS-1:0] fwd_rd,
  output logic [DATA_WIDTH-1:0]     fwd_data,
  output logic                      fwd_busy,
`endif
  output logic [CNT_WIDTH-1:0]      retired
);

  localparam logic [LOG2_REGISTERS-1:0] RD_ZERO = {LOG2_REGISTERS{1'b0}};
  localparam logic [CNT_WIDTH-1:0]      CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  wb_state_t                 state_q, state_d;
  logic [LOG2_REGISTERS-1:0] rd_q, rd_d;
  logic [2:0]                f3_q, f3_d;
  logic [1:0]                alo_q, alo_d;
  logic [LOG2_REGISTERS-1:0] addr_rd_q, addr_rd_d;
  logic [DATA_WIDTH-1:0]     data_rd_q, data_rd_d;
  logic                      rf_enable_q, rf_enable_d;
  logic                      load_misalign_q, load_misalign_d;
  logic [CNT_WIDTH-1:0]      retired_q, retired_d;
  logic [DATA_WIDTH-1:0]     aligned_s;
  logic                      misaligned_s;

  load_aligner #(.DW(DATA_WIDTH)) u_load_aligner (
    .funct3     (f3_q),
    .addr_lo    (alo_q),
    .rdata      (mem_rdata),
    .data       (aligned_s),
    .misaligned (misaligned_s)
  );

  // Held low while reset is asserted so nothing is accepted during reset.
  assign ex_ready = (state_q == WB_IDLE) & rst;

  // Next-state and write-port logic; strobes default low so they pulse once.
  always_comb begin
    state_d         = state_q;
    rd_d            = rd_q;
    f3_d            = f3_q;
    alo_d           = alo_q;
    addr_rd_d       = addr_rd_q;
    data_rd_d       = data_rd_q;
    rf_enable_d     = 1'b0;
    load_misalign_d = 1'b0;
    retired_d       = retired_q;
    case (state_q)
      WB_IDLE: begin
        if (ex_valid && ex_ready) begin
          if (ex_is_load) begin
            rd_d    = ex_rd;
            f3_d    = ex_funct3;
            alo_d   = ex_addr_lo;
            state_d = WB_WAIT_MEM;
          end else begin
            retired_d = retired_q + CNT_ONE;
            if (ex_rd != RD_ZERO) begin
              rf_enable_d = 1'b1;
              addr_rd_d   = ex_rd;
              data_rd_d   = ex_result;
            end else begin
              rf_enable_d = 1'b0;
            end
          end
        end else begin
          state_d = WB_IDLE;
        end
      end
      WB_WAIT_MEM: begin
        if (mem_rvalid) begin
          state_d   = WB_IDLE;
          retired_d = retired_q + CNT_ONE;
          if (misaligned_s) begin
            load_misalign_d = 1'b1;
          end else if (rd_q != RD_ZERO) begin
            rf_enable_d = 1'b1;
            addr_rd_d   = rd_q;
            data_rd_d   = aligned_s;
          end else begin
            rf_enable_d = 1'b0;
          end
        end else begin
          state_d = WB_WAIT_MEM;
        end
      end
      default: begin
        state_d = WB_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any load in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= WB_IDLE;
      rd_q            <= RD_ZERO;
      f3_q            <= 3'd0;
      alo_q           <= 2'd0;
      addr_rd_q       <= RD_ZERO;
      data_rd_q       <= {DATA_WIDTH{1'b0}};
      rf_enable_q     <= 1'b0;
      load_misalign_q <= 1'b0;
      retired_q       <= {CNT_WIDTH{1'b0}};
    end else begin
      state_q         <= state_d;
      rd_q            <= rd_d;
      f3_q            <= f3_d;
      alo_q           <= alo_d;
      addr_rd_q       <= addr_rd_d;
      data_rd_q       <= data_rd_d;
      rf_enable_q     <= rf_enable_d;
      load_misalign_q <= load_misalign_d;
      retired_q       <= retired_d;
    end
  end

  assign addr_rd       = addr_rd_q;
  assign data_rd       = data_rd_q;
  assign rf_enable     = rf_enable_q;
  assign load_misalign = load_misalign_q;
  assign retired       = retired_q;

`ifdef WB_FORWARD_EN
  assign fwd_valid = rf_enable_q;
  assign fwd_rd    = addr_rd_q;
  assign fwd_data  = data_rd_q;
  assign fwd_busy  = (state_q == WB_WAIT_MEM);
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage: ALU writes, aligned loads,
// misaligned loads, rd=0, spurious responses and reset mid-load.
module tb_writeback_stage;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic [4:0]  ex_rd;
  logic [31:0] ex_result;
  logic        ex_is_load;
  logic [2:0]  ex_funct3;
  logic [1:0]  ex_addr_lo;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [4:0]  addr_rd;
  logic [31:0] data_rd;
  logic        rf_enable;
  logic        load_misalign;
  logic [31:0] retired;
`ifdef WB_FORWARD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic        fwd_busy;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  writeback_stage dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_rd         (ex_rd),
    .ex_result     (ex_result),
    .ex_is_load    (ex_is_load),
    .ex_funct3     (ex_funct3),
    .ex_addr_lo    (ex_addr_lo),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .addr_rd       (addr_rd),
    .data_rd       (data_rd),
    .rf_enable     (rf_enable),
    .load_misalign (load_misalign),
`ifdef WB_FORWARD_EN
    .fwd_valid     (fwd_valid),
    .fwd_rd        (fwd_rd),
    .fwd_data      (fwd_data),
    .fwd_busy      (fwd_busy),
`endif
    .retired       (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_fwd(input string tag, input logic busy_exp);
`ifdef WB_FORWARD_EN
    chk({tag, "_fwd_valid"}, {31'd0, fwd_valid}, {31'd0, rf_enable});
    chk({tag, "_fwd_rd"},    {27'd0, fwd_rd},    {27'd0, addr_rd});
    chk({tag, "_fwd_data"},  fwd_data,           data_rd);
    chk({tag, "_fwd_busy"},  {31'd0, fwd_busy},  {31'd0, busy_exp});
`else
    if (tag.len() > 0 && busy_exp === 1'bx) $display("[TB] note %s", tag);
`endif
  endtask

  task automatic chk_port(input string tag, input logic en, input logic [4:0] rd,
                          input logic [31:0] data, input logic mis, input logic [31:0] ret);
    chk({tag, "_rf_enable"}, {31'd0, rf_enable},     {31'd0, en});
    chk({tag, "_addr_rd"},   {27'd0, addr_rd},       {27'd0, rd});
    chk({tag, "_data_rd"},   data_rd,                data);
    chk({tag, "_misalign"},  {31'd0, load_misalign}, {31'd0, mis});
    chk({tag, "_retired"},   retired,                ret);
  endtask

  // Offer a load, wait gap cycles after acceptance, then pulse the response.
  task automatic do_load(input string tag, input logic [4:0] rd, input logic [2:0] f3,
                         input logic [1:0] alo, input logic [31:0] rdata, input int gap);
    chk({tag, "_ready_before"}, {31'd0, ex_ready}, 32'd1);
    ex_valid   = 1'b1;
    ex_is_load = 1'b1;
    ex_rd      = rd;
    ex_funct3  = f3;
    ex_addr_lo = alo;
    ex_result  = 32'h5555_AAAA;
    @(negedge clk);
    ex_valid   = 1'b0;
    ex_is_load = 1'b0;
    chk({tag, "_ready_wait"}, {31'd0, ex_ready}, 32'd0);
    chk_fwd({tag, "_wait"}, 1'b1);
    for (int i = 1; i < gap; i++) begin
      @(negedge clk);
      chk({tag, "_ready_wait_n"}, {31'd0, ex_ready}, 32'd0);
    end
    mem_rvalid = 1'b1;
    mem_rdata  = rdata;
    @(negedge clk);
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0000_0000;
  endtask

  initial begin
    rst        = 1'b0;
    ex_valid   = 1'b0;
    ex_rd      = 5'd0;
    ex_result  = 32'h0000_0000;
    ex_is_load = 1'b0;
    ex_funct3  = 3'd0;
    ex_addr_lo = 2'd0;
    mem_rvalid = 1'b0;
    mem_rdata  = 32'h0000_0000;

    #2;
    chk("reset_ready", {31'd0, ex_ready}, 32'd0);
    chk_port("reset", 1'b0, 5'd0, 32'h0000_0000, 1'b0, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("ready_after_reset", {31'd0, ex_ready}, 32'd1);

    // ALU op rd=5
    ex_valid  = 1'b1;
    ex_rd     = 5'd5;
    ex_result = 32'hDEAD_BEEF;
    @(negedge clk);
    ex_valid = 1'b0;
    chk_port("alu_rd5", 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 32'd1);
    chk_fwd("alu_rd5", 1'b0);
    @(negedge clk);
    chk_port("alu_hold", 1'b0, 5'd5, 32'hDEAD_BEEF, 1'b0, 32'd1);

    // Back-to-back ALU accepts
    ex_valid  = 1'b1;
    ex_rd     = 5'd1;
    ex_result = 32'h0000_0011;
    @(negedge clk);
    chk_port("b2b_a", 1'b1, 5'd1, 32'h0000_0011, 1'b0, 32'd2);
    ex_rd     = 5'd2;
    ex_result = 32'h0000_0022;
    @(negedge clk);
    ex_valid = 1'b0;
    chk_port("b2b_b", 1'b1, 5'd2, 32'h0000_0022, 1'b0, 32'd3);

    // LB rd=3 addr_lo=3, response 4 cycles later
    do_load("lb", 5'd3, 3'd0, 2'd3, 32'h80FF_0000, 4);
    chk_port("lb", 1'b1, 5'd3, 32'hFFFF_FF80, 1'b0, 32'd4);
    chk("lb_ready_after", {31'd0, ex_ready}, 32'd1);

    do_load("lhu", 5'd7, 3'd5, 2'd2, 32'hBEEF_1234, 1);
    chk_port("lhu", 1'b1, 5'd7, 32'h0000_BEEF, 1'b0, 32'd5);
    do_load("lh", 5'd8, 3'd1, 2'd2, 32'hBEEF_1234, 2);
    chk_port("lh", 1'b1, 5'd8, 32'hFFFF_BEEF, 1'b0, 32'd6);
    do_load("lh_lo", 5'd9, 3'd1, 2'd0, 32'h1234_8001, 1);
    chk_port("lh_lo", 1'b1, 5'd9, 32'hFFFF_8001, 1'b0, 32'd7);

    // Response in the acceptance cycle must be ignored
    ex_valid   = 1'b1;
    ex_is_load = 1'b1;
    ex_rd      = 5'd4;
    ex_funct3  = 3'd4;
    ex_addr_lo = 2'd1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFF_FFFF;
    @(negedge clk);
    ex_valid   = 1'b0;
    ex_is_load = 1'b0;
    mem_rvalid = 1'b0;
    chk_port("same_cycle_rvalid", 1'b0, 5'd9, 32'hFFFF_8001, 1'b0, 32'd7);
    chk("same_cycle_ready", {31'd0, ex_ready}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_8056;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk_port("lbu", 1'b1, 5'd4, 32'h0000_0080, 1'b0, 32'd8);

    do_load("lw", 5'd6, 3'd2, 2'd0, 32'hCAFE_F00D, 3);
    chk_port("lw", 1'b1, 5'd6, 32'hCAFE_F00D, 1'b0, 32'd9);
    do_load("f3_other", 5'd10, 3'd7, 2'd0, 32'h0BAD_CAFE, 1);
    chk_port("f3_other", 1'b1, 5'd10, 32'h0BAD_CAFE, 1'b0, 32'd10);

    // Misaligned LW
    do_load("lw_mis", 5'd11, 3'd2, 2'd1, 32'h1111_2222, 2);
    chk_port("lw_mis", 1'b0, 5'd10, 32'h0BAD_CAFE, 1'b1, 32'd11);
    @(negedge clk);
    chk_port("lw_mis_after", 1'b0, 5'd10, 32'h0BAD_CAFE, 1'b0, 32'd11);
    do_load("lhu_mis", 5'd12, 3'd5, 2'd3, 32'h3333_4444, 1);
    chk_port("lhu_mis", 1'b0, 5'd10, 32'h0BAD_CAFE, 1'b1, 32'd12);

    // ALU op to rd=0, then spurious response in IDLE
    ex_valid  = 1'b1;
    ex_rd     = 5'd0;
    ex_result = 32'h0000_1234;
    @(negedge clk);
    ex_valid = 1'b0;
    chk_port("alu_rd0", 1'b0, 5'd10, 32'h0BAD_CAFE, 1'b0, 32'd13);
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h7777_7777;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk_port("spurious_rvalid", 1'b0, 5'd10, 32'h0BAD_CAFE, 1'b0, 32'd13);
    chk("spurious_ready", {31'd0, ex_ready}, 32'd1);

    // Reset during WAIT_MEM aborts the load
    ex_valid   = 1'b1;
    ex_is_load = 1'b1;
    ex_rd      = 5'd13;
    ex_funct3  = 3'd2;
    ex_addr_lo = 2'd0;
    @(negedge clk);
    ex_valid   = 1'b0;
    ex_is_load = 1'b0;
    chk_fwd("pre_reset_wait", 1'b1);
    rst = 1'b0;
    #1;
    chk_port("mid_reset", 1'b0, 5'd0, 32'h0000_0000, 1'b0, 32'd0);
    chk("mid_reset_ready", {31'd0, ex_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h9999_9999;
    @(negedge clk);
    mem_rvalid = 1'b0;
    chk_port("post_reset_rvalid", 1'b0, 5'd0, 32'h0000_0000, 1'b0, 32'd0);
    chk("post_reset_ready", {31'd0, ex_ready}, 32'd1);
    chk_fwd("post_reset", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
